// File: rtl/register_32b.sv
// register_32b
//   WIDTH-bit D-type storage register with a load enable. This is the basic
//   state element for datapath registers such as register-file entries and
//   pipeline latches.
//
// Parameters
//   WIDTH        data width of D and Q, legal range 1..64
//   RESET_VALUE  value forced onto Q while Reset is low
//
// Ports
//   Clock  in   rising-edge clock
//   Reset  in   asynchronous, active-low reset (0 = held in reset)
//   D      in   WIDTH-bit data to capture
//   E      in   load enable, sampled on the rising edge of Clock
//   Q      out  stored value, driven straight from the flops
//
// Behaviour
//   Reset low forces Q to RESET_VALUE without waiting for a clock edge, and
//   keeps it there whatever Clock, E and D do. Releasing Reset leaves Q
//   unchanged. On a rising edge with E high, all WIDTH bits load from D
//   together. With E low, Q holds. Q has no combinational path from D or E.

module register_32b #(
  parameter int unsigned       WIDTH       = 32,
  parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] D,
  input  logic             E,
  output logic [WIDTH-1:0] Q
);

  // Reset sits in the sensitivity list, so it takes effect immediately and
  // wins over a load on a coincident clock edge.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      Q <= RESET_VALUE;
    end else if (E) begin
      Q <= D;
    end
  end

endmodule

// File: tb/tb_register_32b.sv
module tb_register_32b;

  logic        clk;
  logic        rst_a;
  logic [31:0] d_a;
  logic        e_a;
  logic [31:0] q_a;

  logic        rst_b8;
  logic [7:0]  d_b;
  logic        e_b;
  logic [7:0]  q_b;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_q[$];

  typedef struct {
    string       name;
    logic [31:0] d;
    logic        e;
    logic [31:0] q;
  } vec_t;

  vec_t vecs[7];

  register_32b dut_a (
    .Clock (clk),
    .Reset (rst_a),
    .D     (d_a),
    .E     (e_a),
    .Q     (q_a)
  );

  register_32b #(.WIDTH(8), .RESET_VALUE(8'h5A)) dut_b (
    .Clock (clk),
    .Reset (rst_b8),
    .D     (d_b),
    .E     (e_b),
    .Q     (q_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive at the falling edge, queue the expected value, compare just after
  // the following rising edge.
  task automatic step(input string name, input logic [31:0] d, input logic e,
                      input logic [31:0] exp);
    @(negedge clk);
    d_a = d;
    e_a = e;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      errors++;
      checks++;
      $display("FAIL %s: scoreboard empty got %h expected entry", name, q_a);
    end else begin
      check32(name, q_a, exp_q.pop_front());
    end
  endtask

  initial begin
    logic [31:0] model;
    logic [31:0] one;

    vecs[0] = '{"hold0", 32'h1234_5678, 1'b0, 32'hA5A5_5A5A};
    vecs[1] = '{"hold1", 32'h1234_5678, 1'b0, 32'hA5A5_5A5A};
    vecs[2] = '{"hold2", 32'h1234_5678, 1'b0, 32'hA5A5_5A5A};
    vecs[3] = '{"load_cafe", 32'hCAFE_F00D, 1'b1, 32'hCAFE_F00D};
    vecs[4] = '{"hold_cafe", 32'h0000_0000, 1'b0, 32'hCAFE_F00D};
    vecs[5] = '{"load_zero", 32'h0000_0000, 1'b1, 32'h0000_0000};
    vecs[6] = '{"load_a5", 32'hA5A5_5A5A, 1'b1, 32'hA5A5_5A5A};

    rst_a  = 1'b1;
    rst_b8 = 1'b1;
    d_a    = 32'hFFFF_FFFF;
    e_a    = 1'b1;
    d_b    = 8'hC3;
    e_b    = 1'b0;

    // 1: reset asserted between edges acts immediately and holds across edges
    #2;
    rst_a  = 1'b0;
    rst_b8 = 1'b0;
    #1;
    check32("reset_immediate", q_a, 32'h0);
    check32("reset8_value", {24'h0, q_b}, 32'h5A);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check32("reset_hold_edge", q_a, 32'h0);
    end

    // 2: release with E=1; no change until the next rising edge
    @(negedge clk);
    d_a   = 32'hA5A5_5A5A;
    e_a   = 1'b1;
    rst_a = 1'b0;
    #1;
    rst_a = 1'b1;
    #1;
    check32("release_no_change", q_a, 32'h0);
    exp_q.push_back(32'hA5A5_5A5A);
    @(posedge clk);
    #1;
    check32("first_load", q_a, exp_q.pop_front());

    // 3: table of hold/load vectors
    foreach (vecs[i]) step(vecs[i].name, vecs[i].d, vecs[i].e, vecs[i].q);

    // D changing between edges has no effect
    @(negedge clk);
    e_a = 1'b1;
    d_a = 32'h0F0F_0F0F;
    #1;
    check32("no_comb_path", q_a, 32'hA5A5_5A5A);

    // 4: walking one and walking zero, expected values from a running model
    model = 32'hA5A5_5A5A;
    for (int i = 0; i < 32; i++) begin
      one   = 32'h1 << i;
      model = one;
      step("walk_one", one, 1'b1, model);
    end
    for (int i = 0; i < 32; i++) begin
      one   = ~(32'h1 << i);
      model = one;
      step("walk_zero", one, 1'b1, model);
    end

    // 5: mid-cycle reset discards stored value; release with E=0 keeps reset value
    step("load_dead", 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF);
    @(posedge clk);
    #3;
    rst_a = 1'b0;
    #1;
    check32("mid_reset", q_a, 32'h0);
    @(negedge clk);
    e_a   = 1'b0;
    d_a   = 32'h5555_AAAA;
    rst_a = 1'b1;
    @(posedge clk);
    #1;
    check32("release_e0_hold", q_a, 32'h0);

    // reset wins over a load on a coincident edge
    @(negedge clk);
    e_a   = 1'b1;
    d_a   = 32'h7777_7777;
    rst_a = 1'b0;
    @(posedge clk);
    #1;
    check32("reset_beats_load", q_a, 32'h0);
    @(negedge clk);
    rst_a = 1'b1;
    step("load_after_reset", 32'h1357_9BDF, 1'b1, 32'h1357_9BDF);

    // 6: 8-bit instance with non-zero reset value
    @(negedge clk);
    check32("reset8_hold", {24'h0, q_b}, 32'h5A);
    rst_b8 = 1'b1;
    e_b    = 1'b1;
    d_b    = 8'hC3;
    #1;
    check32("release8_no_change", {24'h0, q_b}, 32'h5A);
    @(posedge clk);
    #1;
    check32("load8", {24'h0, q_b}, 32'hC3);
    @(negedge clk);
    e_b = 1'b0;
    d_b = 8'h11;
    @(posedge clk);
    #1;
    check32("hold8", {24'h0, q_b}, 32'hC3);

    if (exp_q.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL scoreboard_drain: got %0d leftover expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
